// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer for the single-issue cpu core.
// Owns pc_en (fetch advance + EX commit) and keeps run-time performance counters.
module cpu_run_ctrl #(
    parameter int PC_W       = 32,
    parameter int CNT_W      = 32,
    parameter int RESET_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             halt_req,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic [2:0]       state,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_HOLD = 3'd0,
        S_HALT = 3'd1,
        S_RUN  = 3'd2,
        S_STEP = 3'd3,
        S_BRK  = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    localparam int HOLD_W = (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    state_t            fsm;
    logic [HOLD_W-1:0] hold_cnt;
    logic              bp_skip;
    logic              run_s1, run_s;
    logic              step_s1, step_s2, step_s3;
    logic              step_rise;
    logic              bp_hit;

    // Board switch and button are asynchronous; step also needs a one-shot edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_s1  <= 1'b0;
            run_s   <= 1'b0;
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_s3 <= 1'b0;
        end else begin
            run_s1  <= run;
            run_s   <= run_s1;
            step_s1 <= step_btn;
            step_s2 <= step_s1;
            step_s3 <= step_s2;
        end
    end

    assign step_rise = step_s2 & ~step_s3;
    assign bp_hit    = bp_en & (pc == bp_addr) & ~bp_skip;

    always_comb begin
        pc_en = 1'b0;
        case (fsm)
            S_RUN:   pc_en = ~bp_hit & ~halt_req;
            S_STEP:  pc_en = ~halt_req;
            default: pc_en = 1'b0;
        endcase
    end

    assign state = fsm;

    // bp_skip lets a resume from a breakpoint execute the breakpoint instruction once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm      <= S_HOLD;
            hold_cnt <= HOLD_INIT;
            bp_skip  <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (fsm)
                S_HOLD: begin
                    if (hold_cnt == HOLD_ONE) begin
                        fsm    <= S_HALT;
                        halted <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_ONE;
                    end
                end
                S_HALT: begin
                    if (run_s) begin
                        fsm     <= S_RUN;
                        halted  <= 1'b0;
                        bp_skip <= 1'b1;
                    end else if (step_rise) begin
                        fsm    <= S_STEP;
                        halted <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        fsm     <= S_ERR;
                        halted  <= 1'b1;
                        bp_skip <= 1'b0;
                    end else if (bp_hit) begin
                        fsm     <= S_BRK;
                        halted  <= 1'b1;
                        bp_skip <= 1'b0;
                    end else if (!run_s) begin
                        fsm     <= S_HALT;
                        halted  <= 1'b1;
                        bp_skip <= 1'b0;
                    end else if (pc_en) begin
                        bp_skip <= 1'b0;
                    end
                end
                S_STEP: begin
                    halted <= 1'b1;
                    fsm    <= halt_req ? S_ERR : S_HALT;
                end
                S_BRK: begin
                    if (!run_s) begin
                        fsm <= S_HALT;
                    end
                end
                S_ERR: begin
                    fsm <= S_ERR;
                end
                default: begin
                    fsm    <= S_HOLD;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    // A same-cycle clear beats the increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (clr_cnt) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (fsm == S_RUN || fsm == S_STEP) begin
                cycle_cnt <= cycle_cnt + CNT_ONE;
            end
            if (pc_en) begin
                instr_cnt <= instr_cnt + CNT_ONE;
            end
        end
    end

endmodule
